switch_input_ctrl: RTL

SWITCH_INPUT_CTRL -- requirements
Module: switch_input_ctrl

---
 rtl/switch_input_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/switch_input_ctrl.sv
// Hex number entry front-end: synchronizes switches/buttons, edge-detects button
// presses, edits an 8-digit buffer and hands committed numbers downstream.
// Optional build macro SWITCH_INPUT_DEBOUNCE_EN adds per-button debounce filters.
module switch_input_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sw,
  input  logic        btn_add,
  input  logic        btn_del,
  input  logic        btn_enter,
  input  logic        flag,
  output logic [31:0] data,
  output logic        write_enable,
  output logic [31:0] display,
  output logic [3:0]  digit_count,
  output logic        pending,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  sync1_q, sync2_q;
  logic [2:0]  btn_sync, filt, prev_q, pulse;
  logic [3:0]  sw_sync;
  logic [31:0] display_q, display_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  count_q, count_d;
  logic        we_q;

  // Bit order: {sw[3:0], enter, del, add}
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sw, btn_enter, btn_del, btn_add};
      sync2_q <= sync1_q;
    end
  end

  assign btn_sync = sync2_q[2:0];
  assign sw_sync  = sync2_q[6:3];

`ifdef SWITCH_INPUT_DEBOUNCE_EN
  logic [2:0]  filt_q;
  logic [19:0] cnt_q [3];

  // Level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (btn_sync[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] >= DEBOUNCE_CYCLES - 20'd1) begin
          filt_q[i] <= btn_sync[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 20'd1;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = btn_sync;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= '0;
    else      prev_q <= filt;
  end

  assign pulse = filt & ~prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EDIT;
      display_q <= '0;
      data_q    <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      display_q <= display_d;
      data_q    <= data_d;
      count_q   <= count_d;
      we_q      <= (state_d == WRITE);
    end
  end

  // Priority inside EDIT: enter, then delete, then add.
  always_comb begin
    state_d   = state_q;
    display_d = display_q;
    data_d    = data_q;
    count_d   = count_q;
    case (state_q)
      EDIT: begin
        if (pulse[2]) begin
          data_d  = display_q;
          state_d = WAIT;
        end else if (pulse[1]) begin
          if (count_q != 4'd0) begin
            display_d = display_q >> 4;
            count_d   = count_q - 4'd1;
          end
        end else if (pulse[0]) begin
          if (count_q < 4'd8) begin
            display_d = {display_q[27:0], sw_sync};
            count_d   = count_q + 4'd1;
          end
        end
      end
      WAIT: begin
        if (flag) state_d = WRITE;
      end
      WRITE: begin
        state_d   = EDIT;
        display_d = '0;
        count_d   = '0;
      end
      default: state_d = EDIT;
    endcase
  end

  assign data         = data_q;
  assign write_enable = we_q;
  assign display      = display_q;
  assign digit_count  = count_q;
  assign pending      = (state_q == WAIT) || (state_q == WRITE);
  assign state_dbg    = state_q;

endmodule
